// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x WIDTH register file with NRD combinational
// read ports, one write port and a sequential bulk-clear engine that
// zeroes one entry per cycle while clrBusy is high.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.

// Single read port: array mux with out-of-range returning 0, plus optional
// forwarding of the in-flight write.
module regfile_rd_port #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [ADDR_W-1:0]           sel,
  input  logic                        byp_hit,
  input  logic [WIDTH-1:0]            byp_data,
  output logic [WIDTH-1:0]            data
);
  logic [WIDTH-1:0] arr_data;

  // Array mux; selects with no matching entry fall through to zero
  always_comb begin
    arr_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel == ADDR_W'(i)) arr_data = mem[i];
  end

`ifdef REGFILE_BYPASS_EN
  assign data = byp_hit ? byp_data : arr_data;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_hit, byp_data};
  assign data       = arr_data;
`endif
endmodule

module regfile_multiport #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   readRegSel,
  output logic [NRD*WIDTH-1:0]    readData,
  input  logic [ADDR_W-1:0]       writeRegSel,
  input  logic [WIDTH-1:0]        writeData,
  input  logic                    writeEn,
  input  logic                    clrReq,
  output logic                    clrBusy,
  output logic                    err
);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] sel;
    logic [WIDTH-1:0]  data;
  } wr_req_t;

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           ptr, ptr_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        sel_ok;
  wr_req_t                     wr;
  logic [NRD-1:0]              byp_hit;

  assign sel_ok = ({1'b0, writeRegSel} < DEPTH_W);
  // Writes are dropped entirely while the sweep owns the array
  assign wr = '{en: writeEn && !clrBusy && sel_ok, sel: writeRegSel, data: writeData};

  // Clear FSM state and sweep pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: a request in CLEAR is ignored, sweep ends after the last entry
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: if (clrReq) begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
      CLEAR: if (ptr == LAST) begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end else begin
        ptr_nxt = ptr + 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    clrBusy = (state == CLEAR);
  end

  // Array: sweep zeroes entry ptr, otherwise accepted write commits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clrBusy && ptr == ADDR_W'(i))       mem[i] <= '0;
        else if (wr.en && wr.sel == ADDR_W'(i)) mem[i] <= wr.data;
      end
    end
  end

  // Error flag; only the X check survives while reset is held
  always_comb begin
    err = $isunknown({writeEn, writeData}) ||
          (rst && writeEn && (clrBusy || !sel_ok));
  end

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      assign byp_hit[p] = wr.en && rst && (readRegSel[p*ADDR_W +: ADDR_W] == wr.sel);
      regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd (
        .mem      (mem),
        .sel      (readRegSel[p*ADDR_W +: ADDR_W]),
        .byp_hit  (byp_hit[p]),
        .byp_data (wr.data),
        .data     (readData[p*WIDTH +: WIDTH])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: main DEPTH=8 instance plus a
// DEPTH=6 instance for out-of-range selects.
module tb_regfile_multiport;
  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [5:0]  readRegSel = '0;
  logic [31:0] readData;
  logic [2:0]  writeRegSel = '0;
  logic [15:0] writeData = '0;
  logic        writeEn = 1'b0;
  logic        clrReq = 1'b0;
  logic        clrBusy;
  logic        err;

  logic [5:0]  rsel6 = '0;
  logic [31:0] rdata6;
  logic [2:0]  wsel6 = '0;
  logic [15:0] wdata6 = '0;
  logic        we6 = 1'b0;
  logic        busy6;
  logic        err6;

  int n_chk = 0;
  int n_err = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [15:0] SAME_EXP = 16'hBEEF;
`else
  localparam logic [15:0] SAME_EXP = 16'h0000;
`endif

  always #5 clk = ~clk;

  regfile_multiport u_dut (
    .clk(clk), .rst(rst), .readRegSel(readRegSel), .readData(readData),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .clrReq(clrReq), .clrBusy(clrBusy), .err(err)
  );

  regfile_multiport #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .NRD(2)) u_dut6 (
    .clk(clk), .rst(rst), .readRegSel(rsel6), .readData(rdata6),
    .writeRegSel(wsel6), .writeData(wdata6), .writeEn(we6),
    .clrReq(1'b0), .clrBusy(busy6), .err(err6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_rd", readData, 32'h0);
    chk("rst_busy", {31'b0, clrBusy}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    readRegSel = {3'd3, 3'd0};
    #1;
    chk("post_rst_rd", readData, 32'h0);
    chk("post_rst_busy", {31'b0, clrBusy}, 32'h0);
    chk("post_rst_err", {31'b0, err}, 32'h0);

    // write BEEF to 5, same-cycle then next-cycle read
    tick();
    writeEn = 1'b1; writeRegSel = 3'd5; writeData = 16'hBEEF;
    readRegSel = {3'd5, 3'd5};
    #1;
    chk("same_cyc_rd", readData, {SAME_EXP, SAME_EXP});
    chk("wr_err", {31'b0, err}, 32'h0);
    tick();
    writeEn = 1'b0;
    #1;
    chk("wr_rd", readData, {16'hBEEF, 16'hBEEF});

    // fill entry k with 1111*k
    for (int k = 0; k < 8; k++) begin
      writeEn = 1'b1; writeRegSel = 3'(k); writeData = 16'(16'h1111 * k);
      tick();
    end
    writeEn = 1'b0;
    readRegSel = {3'd3, 3'd7};
    #1;
    chk("fill_rd", readData, {16'h3333, 16'h7777});

    // clear sweep, E0
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    readRegSel = {3'd1, 3'd7};
    #1;
    chk("clr_busy_e0", {31'b0, clrBusy}, 32'h1);
    chk("clr_rd_e0", readData, {16'h1111, 16'h7777});
    repeat (3) tick();   // E0+3
    readRegSel = {3'd3, 3'd2};
    #1;
    chk("clr_rd_e3_a", readData, {16'h3333, 16'h0000});
    readRegSel = {3'd1, 3'd0};
    #1;
    chk("clr_rd_e3_b", readData, 32'h0);
    // write during clear: flagged, dropped, not forwarded
    writeEn = 1'b1; writeRegSel = 3'd2; writeData = 16'h00AA;
    readRegSel = {3'd2, 3'd2};
    #1;
    chk("clr_wr_err", {31'b0, err}, 32'h1);
    chk("clr_wr_nobyp", readData, 32'h0);
    tick();              // E0+4
    writeEn = 1'b0;
    clrReq = 1'b1;       // sampled at E0+5 while busy: must be ignored
    #1;
    chk("clr_busy_e4", {31'b0, clrBusy}, 32'h1);
    chk("clr_err_clear", {31'b0, err}, 32'h0);
    for (int k = 5; k < 8; k++) begin
      tick();
      clrReq = 1'b0;
      #1;
      chk($sformatf("clr_busy_e%0d", k), {31'b0, clrBusy}, 32'h1);
    end
    tick();              // E0+8
    #1;
    chk("clr_busy_e8", {31'b0, clrBusy}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      readRegSel = {3'(2*i+1), 3'(2*i)};
      #1;
      chk($sformatf("clr_all_%0d", i), readData, 32'h0);
    end

    // first accepted write after sweep
    writeEn = 1'b1; writeRegSel = 3'd2; writeData = 16'h00AA;
    #1;
    chk("post_clr_err", {31'b0, err}, 32'h0);
    tick();
    writeEn = 1'b0;
    readRegSel = {3'd2, 3'd2};
    #1;
    chk("post_clr_rd", readData, {16'h00AA, 16'h00AA});

    // simultaneous write and clear request in IDLE
    writeEn = 1'b1; writeRegSel = 3'd6; writeData = 16'h6666; clrReq = 1'b1;
    tick();              // E1
    writeEn = 1'b0; clrReq = 1'b0;
    readRegSel = {3'd6, 3'd2};
    #1;
    chk("sim_busy", {31'b0, clrBusy}, 32'h1);
    chk("sim_rd", readData, {16'h6666, 16'h00AA});
    repeat (3) tick();   // E1+3
    readRegSel = {3'd6, 3'd2};
    #1;
    chk("mid_rd", readData, {16'h6666, 16'h0000});
    // mid-clear reset
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, clrBusy}, 32'h0);
    chk("mid_rst_rd", readData, 32'h0);
    #2 rst = 1'b1;
    writeEn = 1'b1; writeRegSel = 3'd4; writeData = 16'h1234;
    tick();
    writeEn = 1'b0;
    readRegSel = {3'd4, 3'd4};
    #1;
    chk("after_rst_rd", readData, {16'h1234, 16'h1234});
    chk("after_rst_busy", {31'b0, clrBusy}, 32'h0);

    // DEPTH=6 instance: out-of-range selects
    we6 = 1'b1; wsel6 = 3'd5; wdata6 = 16'h5555;
    tick();
    wsel6 = 3'd7; wdata6 = 16'hDEAD;
    rsel6 = {3'd7, 3'd6};
    #1;
    chk("oor7_err", {31'b0, err6}, 32'h1);
    chk("oor7_rd", rdata6, 32'h0);
    tick();
    wsel6 = 3'd6; wdata6 = 16'hBEEF;
    #1;
    chk("oor6_err", {31'b0, err6}, 32'h1);
    tick();
    we6 = 1'b0;
    rsel6 = {3'd5, 3'd6};
    #1;
    chk("oor_rd_a", rdata6, {16'h5555, 16'h0000});
    rsel6 = {3'd7, 3'd5};
    #1;
    chk("oor_rd_b", rdata6, {16'h0000, 16'h5555});
    chk("oor_err_idle", {31'b0, err6}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
